loop_fifo_reader: RTL
=====================

// Module: loop_fifo_reader
// PURPOSE
// - Drain side of the frame detector loopback FIFO: pops 9-bit beats
//   (byte + drop flag) from the FIFO read port, replays kept frames to the
//   TX AXI-Stream as 8-bit beats, discards flagged frames, inserts an IFG.
// - Starts a frame only once enough data is buffered, to avoid mid-frame
//   underrun; sits between the FIFO master port and the MAC TX path.
// PARAMETERS
// - IFG_CYCLES     12   idle cycles forced after each forwarded frame (0 = none)
// - START_TIMEOUT  255  cycles a pending partial frame waits before start anyway (>=1)
// - CNT_WIDTH      32   width of statistics counters
// PORTS
// - clk              in   1          single clock, all logic on rising edge
// - rst              in   1          asynchronous, active-high reset
// - enable           in   1          allow new frames to start
// - s_axis_prog_empty in  1          FIFO prog_empty (1 = below start threshold)
// - s_axis_tdata     in   9          [7:0] byte, [8] drop flag (sampled on first beat)
// - s_axis_tlast     in   1          last beat of frame
// - s_axis_tvalid    in   1          FIFO beat valid
// - s_axis_tready    out  1          pop FIFO beat
// - m_axis_tdata     out  8          TX byte
// - m_axis_tlast     out  1          TX last beat
// - m_axis_tvalid    out  1          TX beat valid
// - m_axis_tready    in   1          TX ready
// - busy             out  1          1 in any state except IDLE
// - tx_frames        out  CNT_WIDTH  frames forwarded (saturating)
// - drop_frames      out  CNT_WIDTH  frames discarded (saturating)
// BEHAVIOUR
// - Reset: state IDLE, s_axis_tready=0, m_axis_tvalid=0, busy=0, counters=0,
//   timers=0; reset mid-frame abandons frame, no tlast emitted.
// - States: IDLE, WAIT, FORWARD, DROP, GAP.
// - IDLE: if enable & s_axis_tvalid -> WAIT. enable only gates new starts;
//   a frame already in FORWARD/DROP always completes.
// - WAIT: wait_cnt increments each cycle s_axis_tvalid=1, clears to 0 when
//   s_axis_tvalid=0 (back to IDLE if also enable=0). Start when
//   s_axis_prog_empty=0 or wait_cnt==START_TIMEOUT-1: if s_axis_tdata[8]=1
//   -> DROP else -> FORWARD. s_axis_tready=0 in WAIT (no pop).
// - FORWARD: combinational pass-through, zero latency: m_axis_tdata=
//   s_axis_tdata[7:0], m_axis_tlast=s_axis_tlast, m_axis_tvalid=s_axis_tvalid,
//   s_axis_tready=m_axis_tready. Bit 8 ignored after first beat. FIFO empty
//   mid-frame simply stalls tvalid (no error). On tlast handshake:
//   tx_frames++ ; -> GAP if IFG_CYCLES>0 else IDLE.
// - DROP: s_axis_tready=1, m_axis_tvalid=0; pop until tlast beat accepted,
//   then drop_frames++ and -> IDLE (no gap).
// - GAP: s_axis_tready=0, m_axis_tvalid=0 for exactly IFG_CYCLES cycles,
//   then -> IDLE. Earliest next frame first beat: IFG_CYCLES+2 cycles after
//   previous tlast handshake (GAP + IDLE + WAIT with prog_empty=0).
// - Outside FORWARD: m_axis_tdata/tlast = 0. Counters hold at all-ones.
// - Single-beat frame (tlast on first beat) valid in both FORWARD and DROP.
// TESTING
// - 64-byte frame, flag=0, prog_empty=0, tready=1 -> 64 m beats identical
//   bytes, tlast on 64th, tx_frames=1, then 12 cycles tready/tvalid low.
// - Frame with first-beat flag=1 -> all beats popped, m_axis_tvalid never 1,
//   drop_frames=1, next frame starts with no IFG.
// - 10-byte frame, prog_empty held 1, START_TIMEOUT=255 -> first pop
//   exactly 255 cycles after entering WAIT; tvalid gap at cycle 100 restarts count.
// - m_axis_tready toggling 1/0 mid-frame -> no byte lost/duplicated; s_axis_tready
//   mirrors m_axis_tready each cycle.
// - enable=0 mid-frame -> frame completes, next frame not started; rst
//   mid-frame -> all outputs 0 next edge, counters 0.
// - Force tx_frames to all-ones-1, send 2 frames -> saturates at all-ones.

Source files
------------

// File: rtl/loop_fifo_reader.sv
// Drain side of the loopback FIFO: replays kept frames to TX AXI-Stream, discards flagged ones.
// Zero-latency pass-through while forwarding; a frame only starts once enough data is buffered.
module loop_fifo_reader #(
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 255,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 s_axis_prog_empty,
    input  logic [8:0]           s_axis_tdata,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] tx_frames,
    output logic [CNT_WIDTH-1:0] drop_frames
);
    localparam int WW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FORWARD,
        S_DROP,
        S_GAP
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [GW-1:0] gap_cnt;

    assign busy = (state != S_IDLE);

    // Forwarding is a direct wire-through so the MAC sees FIFO data with no added latency.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            S_FORWARD: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata[7:0];
                m_axis_tlast  = s_axis_tlast;
            end
            S_DROP:  s_axis_tready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            tx_frames   <= '0;
            drop_frames <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (enable && s_axis_tvalid) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!s_axis_tvalid) begin
                        wait_cnt <= '0;
                        if (!enable) state <= S_IDLE;
                    end else if (!s_axis_prog_empty || wait_cnt == WAIT_LAST) begin
                        // The drop flag rides on the first beat only.
                        wait_cnt <= '0;
                        state    <= s_axis_tdata[8] ? S_DROP : S_FORWARD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_FORWARD: begin
                    if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                        if (tx_frames != '1) tx_frames <= tx_frames + 1'b1;
                        gap_cnt <= '0;
                        state   <= (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        if (drop_frames != '1) drop_frames <= drop_frames + 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= S_IDLE;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
